// File: rtl/prio_enco_q_if.sv
// Request/index bus of prio_enco_q: request vector in, indexed beats out.
interface prio_enco_q_if #(
  parameter int unsigned N = 8,
  parameter int unsigned W = 3
) ();

  logic [N-1:0] in;
  logic         in_ready;
  logic [W-1:0] y;
  logic         out_valid;
  logic         out_ready;
  logic         last;

  // Request source / consumer side
  modport master (
    output in,
    output out_ready,
    input  in_ready,
    input  y,
    input  out_valid,
    input  last
  );

  // Encoder side
  modport slave (
    input  in,
    input  out_ready,
    output in_ready,
    output y,
    output out_valid,
    output last
  );

endinterface

// File: rtl/prio_enco_q.sv
// Buffered priority encoder: captures a request vector and drains every set
// bit as one index per accepted beat.
// Optional build macro PRIO_ENCO_RR_EN selects round-robin instead of fixed
// highest-index-first selection.
module prio_enco_q #(
  parameter int unsigned N = 8,
  parameter int unsigned W = 3
) (
  input  logic        clk,
  input  logic        rst,
  prio_enco_q_if.slave bus
);

  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

  logic [N-1:0] pend;
  logic [N-1:0] pend_nxt;
  logic [W-1:0] sel_c;
  logic         busy_c;
  logic         last_c;
  logic         ready_c;
  logic         accept_c;
  logic         load_c;

`ifdef PRIO_ENCO_RR_EN
  logic [W-1:0] ptr;
  logic [W-1:0] ptr_nxt;

  // Round-robin pick: first set bit searching down from ptr-1, wrapping.
  // Walk the search order backwards so the earliest hit is written last.
  always_comb begin
    int idx;
    sel_c = '0;
    idx   = 0;
    for (int k = int'(N); k >= 1; k--) begin
      idx = (int'(ptr) + int'(N) - k) % int'(N);
      if (|(pend & (ONE << idx))) sel_c = W'(idx);
    end
  end
`else
  // Fixed pick: highest set index wins (ascending scan, last hit kept).
  always_comb begin
    sel_c = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (|(pend & (ONE << i))) sel_c = W'(i);
    end
  end
`endif

  // Output decode from the pending register; in_ready also follows out_ready.
  always_comb begin
    busy_c   = |pend;
    last_c   = busy_c & $onehot(pend);
    accept_c = busy_c & bus.out_ready;
    ready_c  = ~busy_c | (accept_c & last_c);
    load_c   = ready_c & (|bus.in);
  end

  assign bus.out_valid = busy_c;
  assign bus.y         = sel_c;
  assign bus.last      = last_c;
  assign bus.in_ready  = ready_c;

  // Next state: accept clears the emitted bit, a load overrides it.
  always_comb begin
    pend_nxt = pend;
`ifdef PRIO_ENCO_RR_EN
    ptr_nxt  = ptr;
`endif
    if (accept_c) begin
      pend_nxt = pend & ~(ONE << sel_c);
`ifdef PRIO_ENCO_RR_EN
      ptr_nxt  = sel_c;
`endif
    end
    if (load_c) pend_nxt = bus.in;
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend <= '0;
`ifdef PRIO_ENCO_RR_EN
      ptr  <= '0;
`endif
    end else begin
      pend <= pend_nxt;
`ifdef PRIO_ENCO_RR_EN
      ptr  <= ptr_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_prio_enco_q.sv
// Self-checking bench for prio_enco_q (N=8, W=3): directed scenarios plus
// randomized traffic against a behavioural model.
module tb_prio_enco_q;

  localparam int unsigned N = 8;
  localparam int unsigned W = 3;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  // Behavioural model state
  logic [N-1:0] m_pend;
  int           m_ptr;

  prio_enco_q_if #(.N(N), .W(W)) bus ();

  prio_enco_q #(.N(N), .W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed outputs packed as {out_valid, last, in_ready, y}
  function automatic logic [5:0] obs();
    return {bus.out_valid, bus.last, bus.in_ready, bus.y};
  endfunction

  function automatic logic [5:0] pk(input logic v, input logic l, input logic r, input int yv);
    return {v, l, r, 3'(yv)};
  endfunction

  task automatic drive(input logic [N-1:0] vin, input logic ordy, input logic vrst);
    bus.in        = vin;
    bus.out_ready = ordy;
    rst           = vrst;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Model selection: next index in priority order from the model's pending set
  function automatic int ref_sel(input logic [N-1:0] p, input int ptr);
`ifdef PRIO_ENCO_RR_EN
    for (int k = 1; k <= int'(N); k++) begin
      if (p[(ptr + int'(N) - k) % int'(N)]) return (ptr + int'(N) - k) % int'(N);
    end
`else
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (p[i]) return i;
    end
`endif
    return 0;
  endfunction

  task automatic test_reset();
    drive(8'hFF, 1'b0, 1'b1);
    tick();
    tick();
    drive(8'h00, 1'b0, 1'b0);
    total++;
    if (obs() !== pk(0, 0, 1, 0)) begin
      bad++;
      $display("FAIL reset_out got=%b exp=%b", obs(), pk(0, 0, 1, 0));
    end
    tick();
    total++;
    if (obs() !== pk(0, 0, 1, 0)) begin
      bad++;
      $display("FAIL reset_noload got=%b exp=%b", obs(), pk(0, 0, 1, 0));
    end
  endtask

  task automatic test_basic_drain();
    drive(8'b0001_1000, 1'b1, 1'b0);
    tick();
    drive(8'h00, 1'b1, 1'b0);
    total++;
    if (obs() !== pk(1, 0, 0, 4)) begin
      bad++;
      $display("FAIL basic_y4 got=%b exp=%b", obs(), pk(1, 0, 0, 4));
    end
    tick();
    total++;
    if (obs() !== pk(1, 1, 1, 3)) begin
      bad++;
      $display("FAIL basic_y3 got=%b exp=%b", obs(), pk(1, 1, 1, 3));
    end
    tick();
    total++;
    if (obs() !== pk(0, 0, 1, 0)) begin
      bad++;
      $display("FAIL basic_idle got=%b exp=%b", obs(), pk(0, 0, 1, 0));
    end
  endtask

  task automatic test_backpressure();
    drive(8'b0001_1000, 1'b0, 1'b0);
    tick();
    drive(8'h00, 1'b0, 1'b0);
    for (int c = 0; c < 3; c++) begin
      total++;
      if (obs() !== pk(1, 0, 0, 4)) begin
        bad++;
        $display("FAIL bp_hold cyc=%0d got=%b exp=%b", c, obs(), pk(1, 0, 0, 4));
      end
      tick();
    end
    drive(8'h00, 1'b1, 1'b0);
    total++;
    if (obs() !== pk(1, 0, 0, 4)) begin
      bad++;
      $display("FAIL bp_y4 got=%b exp=%b", obs(), pk(1, 0, 0, 4));
    end
    tick();
    total++;
    if (obs() !== pk(1, 1, 1, 3)) begin
      bad++;
      $display("FAIL bp_y3 got=%b exp=%b", obs(), pk(1, 1, 1, 3));
    end
    tick();
    total++;
    if (obs() !== pk(0, 0, 1, 0)) begin
      bad++;
      $display("FAIL bp_idle got=%b exp=%b", obs(), pk(0, 0, 1, 0));
    end
  endtask

  task automatic test_back_to_back();
    drive(8'b0001_1000, 1'b1, 1'b0);
    tick();
    drive(8'b0000_0011, 1'b1, 1'b0);
    total++;
    if (obs() !== pk(1, 0, 0, 4)) begin
      bad++;
      $display("FAIL b2b_y4 got=%b exp=%b", obs(), pk(1, 0, 0, 4));
    end
    tick();
    total++;
    if (obs() !== pk(1, 1, 1, 3)) begin
      bad++;
      $display("FAIL b2b_y3 got=%b exp=%b", obs(), pk(1, 1, 1, 3));
    end
    tick();
    drive(8'h00, 1'b1, 1'b0);
    total++;
    if (obs() !== pk(1, 0, 0, 1)) begin
      bad++;
      $display("FAIL b2b_y1 got=%b exp=%b", obs(), pk(1, 0, 0, 1));
    end
    tick();
    total++;
    if (obs() !== pk(1, 1, 1, 0)) begin
      bad++;
      $display("FAIL b2b_y0 got=%b exp=%b", obs(), pk(1, 1, 1, 0));
    end
    tick();
    total++;
    if (obs() !== pk(0, 0, 1, 0)) begin
      bad++;
      $display("FAIL b2b_idle got=%b exp=%b", obs(), pk(0, 0, 1, 0));
    end
  endtask

  task automatic test_reset_mid();
    drive(8'h00, 1'b0, 1'b1);
    tick();
    drive(8'hFF, 1'b1, 1'b0);
    tick();
    drive(8'h00, 1'b1, 1'b0);
    total++;
    if (obs() !== pk(1, 0, 0, 7)) begin
      bad++;
      $display("FAIL rmid_y7 got=%b exp=%b", obs(), pk(1, 0, 0, 7));
    end
    tick();
    total++;
    if (obs() !== pk(1, 0, 0, 6)) begin
      bad++;
      $display("FAIL rmid_y6 got=%b exp=%b", obs(), pk(1, 0, 0, 6));
    end
    tick();
    drive(8'h00, 1'b1, 1'b1);
    tick();
    drive(8'h00, 1'b1, 1'b0);
    for (int c = 0; c < 2; c++) begin
      total++;
      if (obs() !== pk(0, 0, 1, 0)) begin
        bad++;
        $display("FAIL rmid_flushed cyc=%0d got=%b exp=%b", c, obs(), pk(0, 0, 1, 0));
      end
      tick();
    end
  endtask

  task automatic test_round_robin();
    int e1;
    int e2;
`ifdef PRIO_ENCO_RR_EN
    e1 = 3;
    e2 = 5;
`else
    e1 = 5;
    e2 = 3;
`endif
    drive(8'h10, 1'b1, 1'b0);
    tick();
    drive(8'h00, 1'b1, 1'b0);
    total++;
    if (obs() !== pk(1, 1, 1, 4)) begin
      bad++;
      $display("FAIL rr_y4 got=%b exp=%b", obs(), pk(1, 1, 1, 4));
    end
    tick();
    drive(8'h28, 1'b1, 1'b0);
    tick();
    drive(8'h00, 1'b1, 1'b0);
    total++;
    if (obs() !== pk(1, 0, 0, e1)) begin
      bad++;
      $display("FAIL rr_first got=%b exp=%b", obs(), pk(1, 0, 0, e1));
    end
    tick();
    total++;
    if (obs() !== pk(1, 1, 1, e2)) begin
      bad++;
      $display("FAIL rr_second got=%b exp=%b", obs(), pk(1, 1, 1, e2));
    end
    tick();
  endtask

  task automatic test_random();
    logic [N-1:0] vin;
    logic         ordy;
    logic         vrst;
    logic         e_v;
    logic         e_l;
    logic         e_r;
    int           e_y;
    drive(8'h00, 1'b0, 1'b1);
    tick();
    m_pend = '0;
    m_ptr  = 0;
    for (int c = 0; c < 400; c++) begin
      vin  = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      ordy = ($urandom_range(0, 3) != 0);
      vrst = ($urandom_range(0, 49) == 0);
      drive(vin, ordy, vrst);
      e_v = (m_pend != 0);
      e_y = e_v ? ref_sel(m_pend, m_ptr) : 0;
      e_l = e_v && ($countones(m_pend) == 1);
      e_r = !e_v || (ordy && e_l);
      total++;
      if (obs() !== pk(e_v, e_l, e_r, e_y)) begin
        bad++;
        $display("FAIL rand cyc=%0d pend=%h got=%b exp=%b", c, m_pend, obs(), pk(e_v, e_l, e_r, e_y));
      end
      if (vrst) begin
        m_pend = '0;
        m_ptr  = 0;
      end else begin
        if (e_v && ordy) begin
          m_pend[e_y] = 1'b0;
          m_ptr       = e_y;
        end
        if (e_r && vin != 0) m_pend = vin;
      end
      tick();
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    drive(8'h00, 1'b0, 1'b1);
    test_reset();
    test_basic_drain();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_round_robin();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
